// File: rtl/muldiv_iter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_iter_if                                        |
// | Brief    : Request/response bundle between execute and muldiv    |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
interface muldiv_iter_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, funct3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, funct3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : muldiv_iter                                           |
// | Brief    : Iterative RV32M-style multiply/divide, 1 bit per cycle |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  wire logic      clk,
  input  wire logic      rst,
  muldiv_iter_if.slave   bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_min_int  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2:0]          r_funct3;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_b;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_fast;
  logic [XLEN-1:0]     w_fast_val;
  logic                w_accept;
  logic [XLEN:0]       w_sum;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_step;
  logic [2*XLEN-1:0]   w_prod_s;
  logic [XLEN-1:0]     w_quo_s;
  logic [XLEN-1:0]     w_rem_s;
  logic [XLEN-1:0]     w_final;

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.result    = r_result;

  assign w_is_div = bus.funct3[2];
  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !bus.flush;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.funct3)
      3'b001:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b010:  w_a_signed = 1'b1;
      3'b100:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b110:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default: begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
    endcase
  end

  assign w_a_neg = w_a_signed && bus.op_a[XLEN-1];
  assign w_b_neg = w_b_signed && bus.op_b[XLEN-1];
  assign w_mag_a = w_a_neg ? -bus.op_a : bus.op_a;
  assign w_mag_b = w_b_neg ? -bus.op_b : bus.op_b;

  // Cases with a fixed architectural answer skip the iteration entirely.
  always_comb begin
    w_fast     = 1'b0;
    w_fast_val = '0;
    if (w_is_div) begin
      if (bus.op_b == '0) begin
        w_fast     = 1'b1;
        w_fast_val = bus.funct3[1] ? bus.op_a : '1;
      end else if (w_a_signed && (bus.op_a == c_min_int) && (bus.op_b == '1)) begin
        w_fast     = 1'b1;
        w_fast_val = bus.funct3[1] ? '0 : bus.op_a;
      end
    end else if ((bus.op_a == '0) || (bus.op_b == '0)) begin
      w_fast     = 1'b1;
      w_fast_val = '0;
    end
  end

  // r_prod holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    w_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_b};
    w_diff = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    if (!r_funct3[2]) begin
      w_step = r_prod[0] ? {w_sum, r_prod[XLEN-1:1]} : {1'b0, r_prod[2*XLEN-1:1]};
    end else begin
      w_step = w_diff[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                            : {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    w_prod_s = r_neg_q ? -w_step : w_step;
    w_quo_s  = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    w_rem_s  = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
    case (r_funct3)
      3'b000:          w_final = w_prod_s[XLEN-1:0];
      3'b100, 3'b101:  w_final = w_quo_s;
      3'b110, 3'b111:  w_final = w_rem_s;
      default:         w_final = w_prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.in_valid) w_state_nxt = w_fast ? S_DONE : S_BUSY;
        S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
        S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_prod   <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (bus.flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_funct3 <= bus.funct3;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_fast) begin
        r_result <= w_fast_val;
        r_cnt    <= '0;
      end else begin
        r_cnt  <= c_cnt_init;
        r_b    <= w_is_div ? w_mag_b : w_mag_a;
        r_prod <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
      end
    end else if (r_state == S_BUSY) begin
      r_prod <= w_step;
      if (r_cnt == '0) r_result <= w_final;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_muldiv_iter                                        |
// | Brief    : Self-checking bench for muldiv_iter (XLEN=32)         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_muldiv_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  muldiv_iter_if #(.XLEN(32)) bus ();
  muldiv_iter #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 0) return 1;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return (a == 0 || b == 0) ? 1 : 33;
  endfunction

  // Issue one op from IDLE, measure accept-to-valid latency, then consume the result.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic abort_test(input bit use_rst, input bit at_done);
    logic [31:0] r;
    int          lat;
    int          seen;
    string       tag;
    tag = use_rst ? (at_done ? "rst_done" : "rst_busy") : (at_done ? "flush_done" : "flush_busy");
    @(negedge clk);
    bus.funct3 = 3'b101; bus.op_a = 32'd1000; bus.op_b = 32'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (at_done) begin
      lat = 1;
      while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      check({tag, "_reach_done"}, 32'(bus.out_valid), 32'd1);
    end else begin
      repeat (4) begin @(posedge clk); #1; end
    end
    if (use_rst) rst = 1'b1; else bus.flush = 1'b1;
    bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    if (use_rst) check({tag, "_result_cleared"}, bus.result, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1; end
    check({tag, "_no_valid_after"}, 32'(seen), 32'd0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat);
    check({tag, "_next_result"}, r, 32'hFFFF_FFFF);
    check({tag, "_next_lat"}, 32'(lat), 32'd33);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, exp, snap;
    logic [31:0] specials[5];
    logic [2:0]  f;
    logic [31:0] a, b;
    int          lat;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_result", bus.result, 32'd0);

    vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3"});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min"});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max"});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_max"});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2"});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2"});
    vecs.push_back('{3'b101, 32'd100,        32'd7,         32'd14,        33, "divu_100_7"});
    vecs.push_back('{3'b111, 32'd100,        32'd7,         32'd2,         33, "remu_100_7"});
    vecs.push_back('{3'b100, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1,  "div_by0"});
    vecs.push_back('{3'b110, 32'd5,          32'd0,         32'd5,         1,  "rem_by0"});
    vecs.push_back('{3'b101, 32'd99,         32'd0,         32'hFFFF_FFFF, 1,  "divu_by0"});
    vecs.push_back('{3'b111, 32'd99,         32'd0,         32'd99,        1,  "remu_by0"});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf"});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf"});
    vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, "divu_no_ovf"});
    vecs.push_back('{3'b001, 32'd0,          32'hFFFF_FFFF, 32'd0,         1,  "mulh_by0"});
    vecs.push_back('{3'b000, 32'hDEAD_BEEF, 32'd0,         32'd0,         1,  "mul_by0"});

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
      check({vecs[i].name, "_result"}, r, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'h7FFF_FFFF;
    for (int n = 0; n < 200; n++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(0, 31);
      run_op(f, a, b, r, lat);
      check($sformatf("rand%0d_f%0d_%08h_%08h", n, f, a, b), r, model(f, a, b));
      check($sformatf("rand%0d_lat", n), 32'(lat), 32'(model_lat(f, a, b)));
    end

    // Backpressure: result must hold and no new op may be taken.
    @(negedge clk);
    bus.funct3 = 3'b011; bus.op_a = 32'h1234_5678; bus.op_b = 32'h9ABC_DEF0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    exp  = model(3'b011, 32'h1234_5678, 32'h9ABC_DEF0);
    check("bp_first_result", bus.result, exp);
    snap = bus.result;
    bus.funct3 = 3'b000; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", c), bus.result, snap);
      check($sformatf("bp_hold%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_hold%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    abort_test(1'b0, 1'b0);
    abort_test(1'b0, 1'b1);
    abort_test(1'b1, 1'b0);
    abort_test(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
